player_shot_ctrl: RTL and testbench
===================================

Name: player_shot_ctrl

Overview:
- Player-bullet engine and hit source for the alien grid: launches one bullet on a fire request and moves it up once per frame.
- After each frame step it scans the alien grid and drives the per-alien alien_hit vector consumed by each alien_single instance.
- Holds a registered hit until the next fsync so the target alien clears its alive flag there, then retires the bullet.
- Sits beside alien_group; its pixel/active outputs feed the top-level pixel mux.

Parameters:
- ALIEN_ROWS, 4, rows in the alien grid.
- ALIEN_COLS, 8, columns in the alien grid.
- BULLET_W, 4, bullet width in pixels.
- BULLET_H, 12, bullet height in pixels.
- BULLET_SPEED, 8, pixels moved up per fsync.
- SCREEN_TOP, 0, top row; the bullet retires once its bottom edge is above this row.

Ports:
- pixel_clk  in  1  pixel clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- fsync  in  1  one-cycle frame-start pulse.
- hpos, vpos  in  12 signed each  current raster position.
- fire  in  1  level fire request, sampled only on fsync.
- shot_x, shot_y  in  12 signed each  bullet launch centre-x and top-y.
- group_lhpos, group_tvpos  in  12 signed each  alien grid origin.
- alien_alive  in  ALIEN_ROWS*ALIEN_COLS  alive flags; index = row*ALIEN_COLS+col.
- alien_hit  out  ALIEN_ROWS*ALIEN_COLS  one-hot hit vector.
- score_pulse  out  1  one-cycle pulse per hit.
- bullet_live  out  1  bullet is on screen.
- bullet_lhpos, bullet_tvpos  out  12 signed each  bullet box origin.
- pixel  out  24  BULLET_COLOR when active, else 0.
- active  out  1  raster is inside a live bullet.

Behaviour:
- Reset (asynchronous, active-high) forces state IDLE and the following output values: alien_hit=0, score_pulse=0, bullet_live=0, bullet_lhpos=0, bullet_tvpos=0, scan index=0.
- State IDLE:
  - On fsync && fire: bullet_lhpos <= shot_x - BULLET_W/2 and bullet_tvpos <= shot_y; go to FLY.
  - fire without fsync is ignored.
- State FLY:
  - bullet_live=1.
  - On fsync: new_tv = bullet_tvpos - BULLET_SPEED.
  - If new_tv + BULLET_H - 1 < SCREEN_TOP: bullet_live <= 0 and go to IDLE (miss).
  - Otherwise load new_tv, set idx <= 0 and go to SCAN.
  - fire is ignored while a bullet is live (one bullet only).
- State SCAN: one alien per cycle, idx = 0 .. N-1.
  - Alien box matches the alien_single geometry:
    - lh = group_lhpos + col*(ENEMY_W+SPACING_X), rh = lh + ENEMY_W - 1.
    - tv = group_tvpos + row*(ENEMY_H+SPACING_Y), bv = tv + ENEMY_H - 1.
  - Overlap test uses inclusive, signed, 12-bit comparisons of the bullet box against the alien box.
  - Hit condition is alien_alive[idx] && overlap. On a hit: alien_hit[idx] <= 1, score_pulse <= 1 for one cycle, bullet_live <= 0, go to HOLD.
  - The lowest matching index wins; only one hit per bullet.
  - If idx = N-1 with no hit: go to FLY.
  - Latency from fsync to hit register is at most N+1 cycles.
  - fsync arriving during SCAN: abort the scan with no hit and process that fsync as in FLY.
- State HOLD:
  - alien_hit stays stable through the next fsync cycle inclusive, so alien_single sees fsync && alien_hit.
  - Cycle after that fsync: alien_hit <= 0, go to IDLE.
  - A fire request on that same fsync is dropped.
- active = bullet_live && bullet_lhpos <= hpos <= bullet_lhpos + BULLET_W - 1 && bullet_tvpos <= vpos <= bullet_tvpos + BULLET_H - 1.
- active and pixel are combinational outputs.
- alien_hit is never asserted for a dead alien; alien_hit is always zero or one-hot.

Decomposition:
- params package additions: ALIEN_ROWS, ALIEN_COLS, BULLET_W, BULLET_H, BULLET_SPEED, BULLET_COLOR, SCREEN_TOP, and shot_state_t enum {IDLE, FLY, SCAN, HOLD}.
- Existing package constants ENEMY_W, ENEMY_H, SPACING_X and SPACING_Y are reused unchanged.
- Natural sub-module: box_overlap, a combinational signed inclusive test of two boxes.
- box_overlap is reusable for alien-bullet versus player collision.

Test Plan:
Bench configuration: ENEMY_W=32, ENEMY_H=24, SPACING_X=16, SPACING_Y=16, group origin (64,40), all aliens alive unless stated.
1. Assert rst mid-SCAN while an alien_hit is pending -> all outputs 0 immediately (asynchronous), state IDLE; next fsync without fire -> bullet_live stays 0.
2. fire=1 with fsync, shot_x=122, shot_y=300 -> bullet_lhpos=120, bullet_tvpos=300; 15th subsequent fsync gives tv=180 -> alien_hit[25]=1 (row3, col1), score_pulse high for one cycle, bullet_live=0; alien_hit stays high through the next fsync, then clears; all within ≤33 cycles of the 15th fsync.
3. Same as 2 but alien_alive[25]=0 -> no hit at tv=180; the 20th fsync gives tv=140 -> alien_hit[17]=1.
4. shot_x=12, shot_y=100 (left of the grid) -> no hit; after the 14th fsync tv=-12, bottom edge -1 < 0 -> bullet_live=0, alien_hit never set.
5. fire held high across fsyncs while a bullet is in FLY -> bullet_tvpos is unaffected and no second bullet is launched; fire on the fsync that clears HOLD is dropped; the following fsync launches a new bullet.
6. Raster check with bullet at (120,300): hpos=120..123 with vpos=300..311 -> active=1 and pixel=BULLET_COLOR; hpos=124 or vpos=312 -> active=0 and pixel=0.

Source files
------------

// File: rtl/player_shot_ctrl_pkg.sv
// Shared constants and types for the player-shot engine.
// Holds the alien grid geometry (reused from the alien_group/alien_single
// side), the bullet geometry and the shot state encoding.
package player_shot_ctrl_pkg;

  // Alien sprite geometry, identical to what alien_single uses.
  localparam int ENEMY_W   = 32;
  localparam int ENEMY_H   = 24;
  localparam int SPACING_X = 16;
  localparam int SPACING_Y = 16;

  // Alien grid size and bullet geometry.
  localparam int ALIEN_ROWS   = 4;
  localparam int ALIEN_COLS   = 8;
  localparam int ALIEN_N      = ALIEN_ROWS * ALIEN_COLS;
  localparam int IDX_W        = (ALIEN_N > 1) ? $clog2(ALIEN_N) : 1;
  localparam int BULLET_W     = 4;
  localparam int BULLET_H     = 12;
  localparam int BULLET_SPEED = 8;
  localparam int SCREEN_TOP   = 0;
  localparam logic [23:0] BULLET_COLOR = 24'hFF_FF_00;

  // Distance between neighbouring alien origins.
  localparam int PITCH_X = ENEMY_W + SPACING_X;
  localparam int PITCH_Y = ENEMY_H + SPACING_Y;

  // Every screen coordinate is a signed 12-bit value.
  typedef logic signed [11:0] coord_t;

  typedef enum logic [1:0] {IDLE, FLY, SCAN, HOLD} shot_state_t;

endpackage

// File: rtl/player_shot_ctrl_if.sv
// Bundle of frame, raster, grid and bullet signals around player_shot_ctrl.
// master : the surrounding system (drives fsync/raster/fire/grid, reads hits)
// slave  : player_shot_ctrl itself
interface player_shot_ctrl_if;
  import player_shot_ctrl_pkg::*;

  logic               fsync;
  coord_t             hpos;
  coord_t             vpos;
  logic               fire;
  coord_t             shot_x;
  coord_t             shot_y;
  coord_t             group_lhpos;
  coord_t             group_tvpos;
  logic [ALIEN_N-1:0] alien_alive;
  logic [ALIEN_N-1:0] alien_hit;
  logic               score_pulse;
  logic               bullet_live;
  coord_t             bullet_lhpos;
  coord_t             bullet_tvpos;
  logic [23:0]        pixel;
  logic               active;

  modport master (
    output fsync, hpos, vpos, fire, shot_x, shot_y, group_lhpos, group_tvpos, alien_alive,
    input  alien_hit, score_pulse, bullet_live, bullet_lhpos, bullet_tvpos, pixel, active
  );

  modport slave (
    input  fsync, hpos, vpos, fire, shot_x, shot_y, group_lhpos, group_tvpos, alien_alive,
    output alien_hit, score_pulse, bullet_live, bullet_lhpos, bullet_tvpos, pixel, active
  );

endinterface

// File: rtl/player_shot_ctrl_box_overlap.sv
// box_overlap: combinational test of whether two axis-aligned boxes share at
// least one pixel. All edges are inclusive and compared as signed values, so
// boxes partly off the top/left of the screen still behave.
// Ports: i_a* / i_b* left, right, top, bottom edges of boxes A and B;
//        o_overlap high when the boxes intersect.
module box_overlap
  import player_shot_ctrl_pkg::*;
(
  input  coord_t i_aLh,
  input  coord_t i_aRh,
  input  coord_t i_aTv,
  input  coord_t i_aBv,
  input  coord_t i_bLh,
  input  coord_t i_bRh,
  input  coord_t i_bTv,
  input  coord_t i_bBv,
  output logic   o_overlap
);

  // Intersect on both axes; a point can be passed as a 1x1 box.
  assign o_overlap = (i_aLh <= i_bRh) && (i_bLh <= i_aRh) &&
                     (i_aTv <= i_bBv) && (i_bTv <= i_aBv);

endmodule

// File: rtl/player_shot_ctrl.sv
// player_shot_ctrl: single player bullet. Launches on fsync && fire, climbs
// BULLET_SPEED pixels per frame, scans the alien grid one alien per cycle
// after every move and raises a one-hot alien_hit that is held through the
// next fsync so the target alien can clear itself on that frame edge.
// Ports: pixel_clk (only clock), rst (async, active high), bus (slave side
//        of player_shot_ctrl_if: frame/raster/fire/grid in, hit/bullet/pixel out).
module player_shot_ctrl
  import player_shot_ctrl_pkg::*;
(
  input logic               pixel_clk,
  input logic               rst,
  player_shot_ctrl_if.slave bus
);

  shot_state_t        r_state, w_nextState;
  coord_t             r_bulletLhpos, r_bulletTvpos, w_nextLhpos, w_nextTvpos;
  logic [IDX_W-1:0]   r_idx, w_nextIdx;
  logic [ALIEN_N-1:0] r_alienHit, w_nextAlienHit;
  logic               r_scorePulse, w_nextScorePulse;
  logic               r_bulletLive, w_nextBulletLive;

  coord_t w_newTv, w_newBottom, w_screenTop;
  coord_t w_bulletRh, w_bulletBv;
  coord_t w_alienLh, w_alienRh, w_alienTv, w_alienBv;
  int     w_row, w_col;
  logic   w_overlap, w_hit, w_miss, w_lastIdx, w_rasterIn, w_active;

  // Frame step: where the bullet would be after this fsync, and whether its
  // bottom edge would then be above the top of the screen.
  assign w_screenTop = coord_t'(SCREEN_TOP);
  assign w_newTv     = r_bulletTvpos - coord_t'(BULLET_SPEED);
  assign w_newBottom = w_newTv + coord_t'(BULLET_H - 1);
  assign w_miss      = (w_newBottom < w_screenTop);

  assign w_bulletRh = r_bulletLhpos + coord_t'(BULLET_W - 1);
  assign w_bulletBv = r_bulletTvpos + coord_t'(BULLET_H - 1);

  // Turn the scan index into the grid position of the alien under test.
  always_comb begin
    w_row = int'(r_idx) / ALIEN_COLS;
    w_col = int'(r_idx) % ALIEN_COLS;
  end

  assign w_alienLh = bus.group_lhpos + coord_t'(w_col * PITCH_X);
  assign w_alienRh = w_alienLh + coord_t'(ENEMY_W - 1);
  assign w_alienTv = bus.group_tvpos + coord_t'(w_row * PITCH_Y);
  assign w_alienBv = w_alienTv + coord_t'(ENEMY_H - 1);

  box_overlap u_alienOverlap (
    .i_aLh(r_bulletLhpos), .i_aRh(w_bulletRh), .i_aTv(r_bulletTvpos), .i_aBv(w_bulletBv),
    .i_bLh(w_alienLh),     .i_bRh(w_alienRh),  .i_bTv(w_alienTv),     .i_bBv(w_alienBv),
    .o_overlap(w_overlap)
  );

  assign w_hit     = bus.alien_alive[r_idx] && w_overlap;
  assign w_lastIdx = (r_idx == IDX_W'(ALIEN_N - 1));

  // The raster position is treated as a 1x1 box against the bullet.
  box_overlap u_rasterOverlap (
    .i_aLh(r_bulletLhpos), .i_aRh(w_bulletRh), .i_aTv(r_bulletTvpos), .i_aBv(w_bulletBv),
    .i_bLh(bus.hpos),      .i_bRh(bus.hpos),   .i_bTv(bus.vpos),      .i_bBv(bus.vpos),
    .o_overlap(w_rasterIn)
  );

  // State register.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic. An fsync during SCAN abandons the scan and is handled
  // exactly like an fsync in FLY; HOLD ignores fire so a request on the
  // clearing fsync is dropped.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (bus.fsync && bus.fire) w_nextState = FLY;
      FLY:  if (bus.fsync) w_nextState = w_miss ? IDLE : SCAN;
      SCAN: begin
        if (bus.fsync)      w_nextState = w_miss ? IDLE : SCAN;
        else if (w_hit)     w_nextState = HOLD;
        else if (w_lastIdx) w_nextState = FLY;
      end
      HOLD: if (bus.fsync) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output/datapath next values. Scanning stops at the first live overlapping
  // alien, so the lowest index wins and alien_hit is at most one-hot.
  always_comb begin
    w_nextLhpos      = r_bulletLhpos;
    w_nextTvpos      = r_bulletTvpos;
    w_nextIdx        = r_idx;
    w_nextAlienHit   = r_alienHit;
    w_nextScorePulse = 1'b0;
    w_nextBulletLive = r_bulletLive;
    case (r_state)
      IDLE: begin
        if (bus.fsync && bus.fire) begin
          w_nextLhpos      = bus.shot_x - coord_t'(BULLET_W / 2);
          w_nextTvpos      = bus.shot_y;
          w_nextBulletLive = 1'b1;
        end
      end
      FLY, SCAN: begin
        if (bus.fsync) begin
          if (w_miss) begin
            w_nextBulletLive = 1'b0;
          end else begin
            w_nextTvpos = w_newTv;
            w_nextIdx   = '0;
          end
        end else if (r_state == SCAN) begin
          if (w_hit) begin
            w_nextAlienHit        = '0;
            w_nextAlienHit[r_idx] = 1'b1;
            w_nextScorePulse      = 1'b1;
            w_nextBulletLive      = 1'b0;
          end else if (!w_lastIdx) begin
            w_nextIdx = r_idx + 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.fsync) w_nextAlienHit = '0;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_bulletLhpos <= '0;
      r_bulletTvpos <= '0;
      r_idx         <= '0;
      r_alienHit    <= '0;
      r_scorePulse  <= 1'b0;
      r_bulletLive  <= 1'b0;
    end else begin
      r_bulletLhpos <= w_nextLhpos;
      r_bulletTvpos <= w_nextTvpos;
      r_idx         <= w_nextIdx;
      r_alienHit    <= w_nextAlienHit;
      r_scorePulse  <= w_nextScorePulse;
      r_bulletLive  <= w_nextBulletLive;
    end
  end

  assign w_active         = r_bulletLive && w_rasterIn;
  assign bus.active       = w_active;
  assign bus.pixel        = w_active ? BULLET_COLOR : 24'h0;
  assign bus.alien_hit    = r_alienHit;
  assign bus.score_pulse  = r_scorePulse;
  assign bus.bullet_live  = r_bulletLive;
  assign bus.bullet_lhpos = r_bulletLhpos;
  assign bus.bullet_tvpos = r_bulletTvpos;

endmodule

// File: tb/tb_player_shot_ctrl.sv
// Testbench for player_shot_ctrl: launches bullets, steps frames, watches the
// hit vector and score pulse, checks the raster window and async reset.
module tb_player_shot_ctrl;
  import player_shot_ctrl_pkg::*;

  localparam int FRAME_GAP = 40;

  logic pixelClk = 1'b0;
  logic rst;

  player_shot_ctrl_if bus ();

  player_shot_ctrl dut (
    .pixel_clk(pixelClk),
    .rst(rst),
    .bus(bus)
  );

  always #5 pixelClk = ~pixelClk;

  int          testsRun = 0;
  int          failures = 0;
  int          invariantErrors = 0;
  string       nameQ[$];
  logic [31:0] valQ[$];

  typedef struct {
    int          h;
    int          v;
    logic        expActive;
    logic [23:0] expPixel;
  } rasterVec_t;

  rasterVec_t vecs[10];

  // Zero-extended 12-bit view of a coordinate for comparison.
  function automatic logic [31:0] c12(input int v);
    logic [11:0] t;
    t = v[11:0];
    return {20'd0, t};
  endfunction

  function automatic logic [31:0] bit32(input int i);
    logic [31:0] t;
    t = 32'd1 << i;
    return t;
  endfunction

  // Queue an expected value when the stimulus is applied.
  task automatic applyStimulus(input string name, input logic [31:0] expVal);
    nameQ.push_back(name);
    valQ.push_back(expVal);
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows.
  task automatic checkOutput(input logic [31:0] actual);
    string       n;
    logic [31:0] e;
    testsRun++;
    if (valQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty: got %0h, required an expectation", actual);
      return;
    end
    n = nameQ.pop_front();
    e = valQ.pop_front();
    if (actual !== e) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", n, actual, e);
    end
  endtask

  task automatic checkNow(input string name, input logic [31:0] expVal, input logic [31:0] actual);
    applyStimulus(name, expVal);
    checkOutput(actual);
  endtask

  // One-cycle fsync; also captures alien_hit while fsync is high.
  task automatic pulseFsync(input logic fireLevel, output logic [31:0] hitDuringFsync);
    @(negedge pixelClk);
    bus.fire  = fireLevel;
    bus.fsync = 1'b1;
    #1 hitDuringFsync = 32'(bus.alien_hit);
    @(negedge pixelClk);
    bus.fsync = 1'b0;
  endtask

  // One whole frame: fsync then FRAME_GAP sampled cycles.
  task automatic runFrame(input logic fireLevel, output int pulses, output logic [31:0] hitVec,
                          output int latency, output logic [31:0] heldAtFsync);
    pulseFsync(fireLevel, heldAtFsync);
    pulses  = 0;
    hitVec  = '0;
    latency = 0;
    for (int c = 1; c <= FRAME_GAP; c++) begin
      if (bus.score_pulse) begin
        pulses++;
        if (latency == 0) begin
          latency = c;
          hitVec  = 32'(bus.alien_hit);
        end
      end
      if (!$onehot0(bus.alien_hit) || ((bus.alien_hit & ~bus.alien_alive) != '0))
        invariantErrors++;
      if (c < FRAME_GAP) @(negedge pixelClk);
    end
  endtask

  task automatic doReset();
    @(negedge pixelClk);
    rst = 1'b1;
    @(negedge pixelClk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          pulses, lat, early;
    logic [31:0] hitVec, held;

    bus.fsync       = 1'b0;
    bus.fire        = 1'b0;
    bus.hpos        = '0;
    bus.vpos        = '0;
    bus.shot_x      = '0;
    bus.shot_y      = '0;
    bus.group_lhpos = 12'sd64;
    bus.group_tvpos = 12'sd40;
    bus.alien_alive = '1;
    rst             = 1'b1;

    vecs[0] = '{120, 300, 1'b1, BULLET_COLOR};
    vecs[1] = '{123, 300, 1'b1, BULLET_COLOR};
    vecs[2] = '{121, 305, 1'b1, BULLET_COLOR};
    vecs[3] = '{123, 311, 1'b1, BULLET_COLOR};
    vecs[4] = '{120, 311, 1'b1, BULLET_COLOR};
    vecs[5] = '{124, 300, 1'b0, 24'h0};
    vecs[6] = '{120, 312, 1'b0, 24'h0};
    vecs[7] = '{119, 305, 1'b0, 24'h0};
    vecs[8] = '{121, 299, 1'b0, 24'h0};
    vecs[9] = '{124, 312, 1'b0, 24'h0};

    // Reset state
    #22;
    checkNow("rst_alien_hit", 0, 32'(bus.alien_hit));
    checkNow("rst_score", 0, 32'(bus.score_pulse));
    checkNow("rst_live", 0, 32'(bus.bullet_live));
    checkNow("rst_lhpos", 0, {20'd0, bus.bullet_lhpos});
    checkNow("rst_tvpos", 0, {20'd0, bus.bullet_tvpos});
    @(negedge pixelClk);
    rst = 1'b0;

    // Launch, raster window, hit on alien 25 at tv=180
    bus.shot_x = 12'sd122;
    bus.shot_y = 12'sd300;
    runFrame(1'b1, pulses, hitVec, lat, held);
    checkNow("launch_live", 1, 32'(bus.bullet_live));
    checkNow("launch_lhpos", c12(120), {20'd0, bus.bullet_lhpos});
    checkNow("launch_tvpos", c12(300), {20'd0, bus.bullet_tvpos});

    for (int i = 0; i < 10; i++) begin
      @(negedge pixelClk);
      bus.hpos = 12'(vecs[i].h);
      bus.vpos = 12'(vecs[i].v);
      applyStimulus($sformatf("raster_active_%0d", i), 32'(vecs[i].expActive));
      applyStimulus($sformatf("raster_pixel_%0d", i), 32'(vecs[i].expPixel));
      #1;
      checkOutput(32'(bus.active));
      checkOutput(32'(bus.pixel));
    end
    bus.hpos = '0;
    bus.vpos = '0;

    early = 0;
    for (int k = 1; k <= 14; k++) begin
      runFrame(1'b0, pulses, hitVec, lat, held);
      if (pulses != 0 || bus.alien_hit != '0) early++;
    end
    checkNow("t2_no_early_hit", 0, 32'(early));
    checkNow("t2_tv_after_14", c12(188), {20'd0, bus.bullet_tvpos});
    runFrame(1'b0, pulses, hitVec, lat, held);
    checkNow("t2_pulse_count", 1, 32'(pulses));
    checkNow("t2_hit_vec", bit32(25), hitVec);
    checkNow("t2_latency_ok", 1, 32'(lat >= 1 && lat <= 33));
    checkNow("t2_tv_180", c12(180), {20'd0, bus.bullet_tvpos});
    checkNow("t2_live_after_hit", 0, 32'(bus.bullet_live));
    checkNow("t2_hit_held", bit32(25), 32'(bus.alien_hit));
    runFrame(1'b0, pulses, hitVec, lat, held);
    checkNow("t2_hit_at_fsync", bit32(25), held);
    checkNow("t2_hit_cleared", 0, 32'(bus.alien_hit));
    checkNow("t2_no_pulse_clear", 0, 32'(pulses));
    checkNow("t2_invariant", 0, 32'(invariantErrors));

    // Dead alien 25 skipped; hit 17 at tv=140; fire held throughout
    doReset();
    bus.alien_alive[25] = 1'b0;
    runFrame(1'b1, pulses, hitVec, lat, held);
    early = 0;
    for (int k = 1; k <= 19; k++) begin
      runFrame(1'b1, pulses, hitVec, lat, held);
      if (pulses != 0 || bus.alien_hit != '0) early++;
    end
    checkNow("t3_no_early_hit", 0, 32'(early));
    checkNow("t3_tv_after_19", c12(148), {20'd0, bus.bullet_tvpos});
    checkNow("t3_lhpos_kept", c12(120), {20'd0, bus.bullet_lhpos});
    runFrame(1'b1, pulses, hitVec, lat, held);
    checkNow("t3_hit_vec", bit32(17), hitVec);
    checkNow("t3_pulse_count", 1, 32'(pulses));
    checkNow("t3_tv_140", c12(140), {20'd0, bus.bullet_tvpos});
    runFrame(1'b1, pulses, hitVec, lat, held);
    checkNow("t5_hit_at_fsync", bit32(17), held);
    checkNow("t5_hit_cleared", 0, 32'(bus.alien_hit));
    checkNow("t5_fire_dropped", 0, 32'(bus.bullet_live));
    runFrame(1'b1, pulses, hitVec, lat, held);
    checkNow("t5_relaunch_live", 1, 32'(bus.bullet_live));
    checkNow("t5_relaunch_tv", c12(300), {20'd0, bus.bullet_tvpos});
    checkNow("t3_invariant", 0, 32'(invariantErrors));
    bus.alien_alive = '1;

    // Bullet left of the grid leaves through the top
    doReset();
    bus.shot_x = 12'sd12;
    bus.shot_y = 12'sd100;
    runFrame(1'b1, pulses, hitVec, lat, held);
    checkNow("t4_lhpos", c12(10), {20'd0, bus.bullet_lhpos});
    early = 0;
    for (int k = 1; k <= 13; k++) begin
      runFrame(1'b0, pulses, hitVec, lat, held);
      if (pulses != 0 || bus.alien_hit != '0) early++;
    end
    checkNow("t4_live_13", 1, 32'(bus.bullet_live));
    checkNow("t4_tv_13", c12(-4), {20'd0, bus.bullet_tvpos});
    runFrame(1'b0, pulses, hitVec, lat, held);
    if (pulses != 0 || bus.alien_hit != '0) early++;
    checkNow("t4_live_14", 0, 32'(bus.bullet_live));
    runFrame(1'b0, pulses, hitVec, lat, held);
    if (pulses != 0 || bus.alien_hit != '0) early++;
    checkNow("t4_stays_dead", 0, 32'(bus.bullet_live));
    checkNow("t4_never_hit", 0, 32'(early));

    // Async reset in the middle of a scan that would hit alien 25
    doReset();
    bus.shot_x = 12'sd122;
    bus.shot_y = 12'sd188;
    runFrame(1'b1, pulses, hitVec, lat, held);
    pulseFsync(1'b0, held);
    repeat (10) @(negedge pixelClk);
    bus.hpos = 12'sd121;
    bus.vpos = 12'sd190;
    #1;
    checkNow("t1_pre_live", 1, 32'(bus.bullet_live));
    checkNow("t1_pre_active", 1, 32'(bus.active));
    checkNow("t1_pre_tv", c12(180), {20'd0, bus.bullet_tvpos});
    rst = 1'b1;
    #1;
    checkNow("t1_rst_live", 0, 32'(bus.bullet_live));
    checkNow("t1_rst_active", 0, 32'(bus.active));
    checkNow("t1_rst_pixel", 0, 32'(bus.pixel));
    checkNow("t1_rst_lhpos", 0, {20'd0, bus.bullet_lhpos});
    checkNow("t1_rst_tvpos", 0, {20'd0, bus.bullet_tvpos});
    @(negedge pixelClk);
    rst = 1'b0;
    runFrame(1'b0, pulses, hitVec, lat, held);
    checkNow("t1_after_live", 0, 32'(bus.bullet_live));
    checkNow("t1_after_pulses", 0, 32'(pulses));
    checkNow("t1_after_hit", 0, 32'(bus.alien_hit));
    checkNow("final_invariant", 0, 32'(invariantErrors));

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
